// File: rtl/decode_stage.sv
// RV32I decode stage: one-hot decode plus operand select into a registered two-entry skid buffer (M/S).
// Define DECODE_ILLEGAL_TRAP_EN to emit illegal words as trap entries; otherwise they are silently dropped.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [36:0]     instructions,
    output logic [XLEN-1:0] v1,
    output logic [XLEN-1:0] v2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] sdata,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      rd,
    output logic            illegal
);
    typedef struct packed {
        logic [36:0]     instructions;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] sdata;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;
    logic [5:0]      idx_s;
    logic            legal_s;
    logic [XLEN-1:0] op1_s, op2_s, imm_sel_s;
    logic [4:0]      rd_sel_s;
    entry_t          dec_s;
    entry_t          m_r, s_r;
    logic            m_valid_r, s_valid_r, in_ready_r;
    logic            push_s, consume_s, s_valid_nxt_s;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign opcode_s = in_instr[6:0];
    assign funct3_s = in_instr[14:12];
    assign funct7_s = in_instr[31:25];
    assign imm_i_s  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_st_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b_s  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_s  = {in_instr[31:12], 12'h000};
    assign imm_j_s  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign shamt_s  = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    // Opcode/funct decode into a one-hot index, legality and operand selection.
    always_comb begin
        legal_s   = 1'b1;
        idx_s     = 6'd0;
        op1_s     = rf_rdata1;
        op2_s     = rf_rdata2;
        imm_sel_s = {XLEN{1'b0}};
        rd_sel_s  = in_instr[11:7];
        case (opcode_s)
            7'b0110011: begin
                legal_s = (funct7_s == 7'b0000000) ||
                          ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
                case (funct3_s)
                    3'b000:  idx_s = funct7_s[5] ? 6'd1 : 6'd0;
                    3'b001:  idx_s = 6'd5;
                    3'b010:  idx_s = 6'd8;
                    3'b011:  idx_s = 6'd9;
                    3'b100:  idx_s = 6'd2;
                    3'b101:  idx_s = funct7_s[5] ? 6'd7 : 6'd6;
                    3'b110:  idx_s = 6'd3;
                    default: idx_s = 6'd4;
                endcase
            end
            7'b0010011: begin
                imm_sel_s = imm_i_s;
                op2_s     = imm_i_s;
                case (funct3_s)
                    3'b000:  idx_s = 6'd10;
                    3'b100:  idx_s = 6'd11;
                    3'b110:  idx_s = 6'd12;
                    3'b111:  idx_s = 6'd13;
                    3'b010:  idx_s = 6'd17;
                    3'b011:  idx_s = 6'd18;
                    3'b001: begin
                        idx_s   = 6'd14;
                        legal_s = (funct7_s == 7'b0000000);
                        op2_s   = shamt_s;
                    end
                    default: begin
                        idx_s   = funct7_s[5] ? 6'd16 : 6'd15;
                        legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
                        op2_s   = shamt_s;
                    end
                endcase
            end
            7'b0000011: begin
                imm_sel_s = imm_i_s;
                op2_s     = imm_i_s;
                case (funct3_s)
                    3'b000:  idx_s = 6'd19;
                    3'b001:  idx_s = 6'd20;
                    3'b010:  idx_s = 6'd21;
                    3'b100:  idx_s = 6'd22;
                    3'b101:  idx_s = 6'd23;
                    default: legal_s = 1'b0;
                endcase
            end
            7'b0100011: begin
                imm_sel_s = imm_st_s;
                op2_s     = imm_st_s;
                rd_sel_s  = 5'd0;
                case (funct3_s)
                    3'b000:  idx_s = 6'd24;
                    3'b001:  idx_s = 6'd25;
                    3'b010:  idx_s = 6'd26;
                    default: legal_s = 1'b0;
                endcase
            end
            7'b1100011: begin
                imm_sel_s = imm_b_s;
                rd_sel_s  = 5'd0;
                case (funct3_s)
                    3'b000:  idx_s = 6'd27;
                    3'b001:  idx_s = 6'd28;
                    3'b100:  idx_s = 6'd29;
                    3'b101:  idx_s = 6'd30;
                    3'b110:  idx_s = 6'd31;
                    3'b111:  idx_s = 6'd32;
                    default: legal_s = 1'b0;
                endcase
            end
            7'b1101111: begin
                idx_s     = 6'd33;
                imm_sel_s = imm_j_s;
                op1_s     = in_pc;
                op2_s     = imm_j_s;
            end
            7'b1100111: begin
                idx_s     = 6'd34;
                legal_s   = (funct3_s == 3'b000);
                imm_sel_s = imm_i_s;
                op2_s     = imm_i_s;
            end
            7'b0110111: begin
                idx_s     = 6'd35;
                imm_sel_s = imm_u_s;
                op1_s     = {XLEN{1'b0}};
                op2_s     = imm_u_s;
            end
            7'b0010111: begin
                idx_s     = 6'd36;
                imm_sel_s = imm_u_s;
                op1_s     = in_pc;
                op2_s     = imm_u_s;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Assemble the buffered entry; an illegal word keeps only its pc and the illegal flag.
    always_comb begin
        dec_s    = {$bits(entry_t){1'b0}};
        dec_s.pc = in_pc;
        if (legal_s) begin
            dec_s.instructions = 37'd1 << idx_s;
            dec_s.v1           = op1_s;
            dec_s.v2           = op2_s;
            dec_s.imm          = imm_sel_s;
            dec_s.sdata        = rf_rdata2;
            dec_s.rd           = rd_sel_s;
        end else begin
            dec_s.illegal = 1'b1;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign push_s = in_valid && in_ready_r;
`else
    assign push_s = in_valid && in_ready_r && legal_s;
`endif
    assign consume_s = m_valid_r && out_ready;

    // S drains whenever M is free or leaving; otherwise it catches a push blocked by a stalled M.
    always_comb begin
        if (consume_s || !m_valid_r) begin
            s_valid_nxt_s = 1'b0;
        end else begin
            s_valid_nxt_s = s_valid_r || push_s;
        end
    end

    // Skid buffer state: reset > flush > handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r        <= {$bits(entry_t){1'b0}};
            s_r        <= {$bits(entry_t){1'b0}};
            m_valid_r  <= 1'b0;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (flush) begin
            m_valid_r  <= 1'b0;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            s_valid_r  <= s_valid_nxt_s;
            in_ready_r <= !s_valid_nxt_s;
            if (consume_s || !m_valid_r) begin
                if (s_valid_r) begin
                    m_r       <= s_r;
                    m_valid_r <= 1'b1;
                end else if (push_s) begin
                    m_r       <= dec_s;
                    m_valid_r <= 1'b1;
                end else begin
                    m_valid_r <= 1'b0;
                end
            end else if (push_s) begin
                s_r <= dec_s;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = m_valid_r;
    assign instructions = m_r.instructions;
    assign v1           = m_r.v1;
    assign v2           = m_r.v2;
    assign imm          = m_r.imm;
    assign sdata        = m_r.sdata;
    assign pc           = m_r.pc;
    assign rd           = m_r.rd;
    assign illegal      = m_r.illegal;
endmodule
